// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM between pixel fetchers.
// Define SPRITE_ROM_ARB_STATS_EN to add the contention_cnt/stats_clr counter.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 2,
  parameter int ROM_LAT = 1,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      rd_valid,
  output logic [IDW-1:0]            rd_id,
  output logic [DATA_W-1:0]         rd_data
`ifdef SPRITE_ROM_ARB_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [15:0]               contention_cnt
`endif
);

  logic [IDW-1:0]     rr_ptr;
  logic               grant_any;
  logic [IDW-1:0]     gnt_idx;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [IDW:0]       cand;

  logic [ROM_LAT:0]   vld_q;
  logic [IDW-1:0]     id_q [ROM_LAT+1];

  // Scan from rr_ptr upward, wrapping, and take the first requester found.
  always_comb begin
    grant_any = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(j);
      if (cand >= (IDW+1)'(NUM_REQ))
        cand = cand - (IDW+1)'(NUM_REQ);
      if (!grant_any && req[cand[IDW-1:0]]) begin
        grant_any = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    gnt_vec = '0;
    if (grant_any && reset_n)
      gnt_vec[gnt_idx] = 1'b1;
  end

  assign gnt = gnt_vec;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      rom_address <= '0;
      vld_q       <= '0;
      for (int s = 0; s <= ROM_LAT; s++)
        id_q[s] <= '0;
    end else begin
      if (grant_any) begin
        rr_ptr <= (gnt_idx == IDW'(NUM_REQ-1)) ? '0
                                               : gnt_idx + 1'b1;
        rom_address <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
      end
      vld_q   <= {vld_q[ROM_LAT-1:0], grant_any};
      id_q[0] <= gnt_idx;
      for (int s = 1; s <= ROM_LAT; s++)
        id_q[s] <= id_q[s-1];
    end
  end

  assign rd_valid = vld_q[ROM_LAT];
  assign rd_id    = id_q[ROM_LAT];
  assign rd_data  = rd_valid ? rom_q : '0;

`ifdef SPRITE_ROM_ARB_STATS_EN
  logic multi_req;

  // Two or more bits set iff clearing the lowest set bit leaves something.
  assign multi_req = (req & (req - NUM_REQ'(1))) != '0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)
      contention_cnt <= '0;
    else if (stats_clr)
      contention_cnt <= '0;
    else if (multi_req && contention_cnt != 16'hFFFF)
      contention_cnt <= contention_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a behavioural 1-cycle ROM.
// Covers reset, single read, round-robin, wrap, back-to-back and async reset.
module tb_sprite_rom_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 2;
  localparam int IDW     = 2;

  logic                      vga_clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q = '0;
  logic                      rd_valid;
  logic [IDW-1:0]            rd_id;
  logic [DATA_W-1:0]         rd_data;
`ifdef SPRITE_ROM_ARB_STATS_EN
  logic                      stats_clr = 1'b0;
  logic [15:0]               contention_cnt;
`endif

  int passed = 0;
  int total  = 0;

  sprite_rom_arbiter dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rd_valid    (rd_valid),
    .rd_id       (rd_id),
    .rd_data     (rd_data)
`ifdef SPRITE_ROM_ARB_STATS_EN
    ,
    .stats_clr      (stats_clr),
    .contention_cnt (contention_cnt)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [1:0] rom_fn(input logic [9:0] a);
    logic [1:0] lo, hi;
    lo = a[1:0];
    hi = a[9:8];
    return lo + hi;
  endfunction

  always @(posedge vga_clk) rom_q <= rom_fn(rom_address);

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req = '1;
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      total++;
      if (gnt !== 4'b0000) $display("FAIL rst_gnt: got %b exp 0000", gnt);
      else passed++;
      total++;
      if (rd_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", rd_valid);
      else passed++;
      total++;
      if (rom_address !== 10'h000) $display("FAIL rst_addr: got %h exp 000", rom_address);
      else passed++;
    end
    tick();
    reset_n = 1'b1;
    req = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      #1;
      total++;
      if (gnt !== 4'b0000 || rd_valid !== 1'b0 || rom_address !== 10'h000)
        $display("FAIL idle: gnt %b valid %b addr %h exp 0000 0 000", gnt, rd_valid, rom_address);
      else passed++;
    end
  endtask

  task automatic test_single;
    tick();
    req = 4'b0100;
    req_addr = {10'h3FF, 10'h155, 10'h2AA, 10'h0F0};
    #1;
    total++;
    if (gnt !== 4'b0100) $display("FAIL single_gnt: got %b exp 0100", gnt);
    else passed++;
    tick();
    req = '0;
    #1;
    total++;
    if (rom_address !== 10'h155) $display("FAIL single_addr: got %h exp 155", rom_address);
    else passed++;
    total++;
    if (rd_valid !== 1'b0) $display("FAIL single_early: got %b exp 0", rd_valid);
    else passed++;
    tick();
    #1;
    total++;
    if (rd_valid !== 1'b1 || rd_id !== 2'd2 || rd_data !== rom_fn(10'h155))
      $display("FAIL single_resp: got %b/%0d/%0d exp 1/2/%0d", rd_valid, rd_id, rd_data, rom_fn(10'h155));
    else passed++;
    tick();
    #1;
    total++;
    if (rd_valid !== 1'b0) $display("FAIL single_after: got %b exp 0", rd_valid);
    else passed++;
  endtask

  task automatic test_round_robin;
    logic [9:0] rr_addr [4];
    logic [3:0] eg;
    rr_addr = '{10'h000, 10'h101, 10'h203, 10'h302};
    tick();
    req = 4'b1000;
    #1;
    total++;
    if (gnt !== 4'b1000) $display("FAIL align_gnt: got %b exp 1000", gnt);
    else passed++;
    tick();
    req = '0;
    tick();
    #1;
    total++;
    if (rd_valid !== 1'b1 || rd_id !== 2'd3)
      $display("FAIL align_resp: got %b/%0d exp 1/3", rd_valid, rd_id);
    else passed++;
    for (int i = 0; i < 4; i++) req_addr[i*ADDR_W +: ADDR_W] = rr_addr[i];
    for (int c = 0; c < 10; c++) begin
      tick();
      req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      eg = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      total++;
      if (gnt !== eg) $display("FAIL rr_gnt c%0d: got %b exp %b", c, gnt, eg);
      else passed++;
      if (c >= 1 && c < 9) begin
        total++;
        if (rom_address !== rr_addr[(c-1)%4])
          $display("FAIL rr_addr c%0d: got %h exp %h", c, rom_address, rr_addr[(c-1)%4]);
        else passed++;
      end
      total++;
      if (rd_valid !== (c >= 2)) $display("FAIL rr_valid c%0d: got %b exp %b", c, rd_valid, c >= 2);
      else passed++;
      if (c >= 2) begin
        total++;
        if (rd_id !== IDW'((c-2)%4) || rd_data !== rom_fn(rr_addr[(c-2)%4]))
          $display("FAIL rr_resp c%0d: got %0d/%0d exp %0d/%0d", c, rd_id, rd_data,
                   (c-2)%4, rom_fn(rr_addr[(c-2)%4]));
        else passed++;
      end
    end
  endtask

  task automatic test_skip_wrap;
    logic [3:0] seq [3];
    seq = '{4'b0001, 4'b0010, 4'b0001};
    tick();
    req = 4'b0100;
    #1;
    total++;
    if (gnt !== 4'b0100) $display("FAIL wrap_pre: got %b exp 0100", gnt);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      tick();
      req = 4'b0011;
      #1;
      total++;
      if (gnt !== seq[c]) $display("FAIL wrap_gnt c%0d: got %b exp %b", c, gnt, seq[c]);
      else passed++;
    end
    tick();
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back;
    logic [9:0] b2b [4];
    logic [3:0] eg;
    b2b = '{10'h001, 10'h102, 10'h203, 10'h300};
    for (int c = 0; c < 6; c++) begin
      tick();
      req = (c < 4) ? 4'b0010 : 4'b0000;
      req_addr[ADDR_W +: ADDR_W] = b2b[c%4];
      #1;
      eg = (c < 4) ? 4'b0010 : 4'b0000;
      total++;
      if (gnt !== eg) $display("FAIL b2b_gnt c%0d: got %b exp %b", c, gnt, eg);
      else passed++;
      if (c >= 2) begin
        total++;
        if (rd_valid !== 1'b1 || rd_id !== 2'd1 || rd_data !== rom_fn(b2b[c-2]))
          $display("FAIL b2b_resp c%0d: got %b/%0d/%0d exp 1/1/%0d", c, rd_valid, rd_id,
                   rd_data, rom_fn(b2b[c-2]));
        else passed++;
      end
    end
  endtask

  task automatic test_withdraw;
    tick();
    req = 4'b1100;
    #1;
    total++;
    if (gnt !== 4'b0100) $display("FAIL wd_gnt: got %b exp 0100", gnt);
    else passed++;
    tick();
    req = '0;
    #1;
    total++;
    if (gnt !== 4'b0000) $display("FAIL wd_gnt2: got %b exp 0000", gnt);
    else passed++;
    tick();
    #1;
    total++;
    if (rd_valid !== 1'b1 || rd_id !== 2'd2)
      $display("FAIL wd_resp: got %b/%0d exp 1/2", rd_valid, rd_id);
    else passed++;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      total++;
      if (rd_valid !== 1'b0) $display("FAIL wd_none c%0d: got %b exp 0", c, rd_valid);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    tick();
    req = 4'b1111;
    #1;
    total++;
    if (gnt !== 4'b1000) $display("FAIL mid_gnt0: got %b exp 1000", gnt);
    else passed++;
    tick();
    #1;
    total++;
    if (gnt !== 4'b0001) $display("FAIL mid_gnt1: got %b exp 0001", gnt);
    else passed++;
    tick();
    req = '0;
    #1;
    total++;
    if (rd_valid !== 1'b1 || rd_id !== 2'd3)
      $display("FAIL mid_pre: got %b/%0d exp 1/3", rd_valid, rd_id);
    else passed++;
    #2;
    reset_n = 1'b0;
    req = 4'b1111;
    #1;
    total++;
    if (rd_valid !== 1'b0 || rom_address !== 10'h000 || gnt !== 4'b0000)
      $display("FAIL mid_async: got %b/%h/%b exp 0/000/0000", rd_valid, rom_address, gnt);
    else passed++;
    tick();
    reset_n = 1'b1;
    req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      total++;
      if (rd_valid !== 1'b0) $display("FAIL mid_stale c%0d: got %b exp 0", c, rd_valid);
      else passed++;
    end
    tick();
    req = 4'b1111;
    #1;
    total++;
    if (gnt !== 4'b0001) $display("FAIL mid_first: got %b exp 0001", gnt);
    else passed++;
    tick();
    req = '0;
    tick();
    tick();
  endtask

`ifdef SPRITE_ROM_ARB_STATS_EN
  task automatic test_stats;
    tick();
    req = '0;
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    #1;
    total++;
    if (contention_cnt !== 16'd0) $display("FAIL stats_pre: got %0d exp 0", contention_cnt);
    else passed++;
    for (int c = 0; c < 8; c++) begin
      req = (c < 5) ? 4'b0011 : 4'b0001;
      tick();
    end
    req = '0;
    #1;
    total++;
    if (contention_cnt !== 16'd5) $display("FAIL stats_cnt: got %0d exp 5", contention_cnt);
    else passed++;
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    #1;
    total++;
    if (contention_cnt !== 16'd0) $display("FAIL stats_clr: got %0d exp 0", contention_cnt);
    else passed++;
    tick();
    tick();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip_wrap();
    test_back_to_back();
    test_withdraw();
    test_reset_mid();
`ifdef SPRITE_ROM_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM between NUM_REQ pixel-fetch requesters, such as per-tower sprite drawers.
- Arbitration is round-robin, at most one grant per cycle, giving 1 read/cycle sustained throughput.
- Drives the ROM address port and returns rom_q tagged with the requester ID after a fixed latency.
- Sits between the tower sprite drawers and the shared sprite ROM/palette path, in the vga_clk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 10, ROM address width
- DATA_W, 2, ROM word width (palette index)
- ROM_LAT, 1, ROM read latency in cycles, counted from rom_address register output to valid rom_q (1..3)

Ports:
- vga_clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester read request; held until granted
- req_addr  in  NUM_REQ*ADDR_W  flat address bus; requester i uses bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted req
- rom_address  out  ADDR_W  registered address to the ROM
- rom_q  in  DATA_W  ROM read data
- rd_valid  out  1  rd_data/rd_id valid this cycle
- rd_id  out  $clog2(NUM_REQ)  requester index for rd_data
- rd_data  out  DATA_W  equals rom_q while rd_valid=1

Behaviour:
- Reset values (async, reset_n=0): rr_ptr=0, rom_address=0, valid/ID pipeline cleared, rd_valid=0, rd_id=0. gnt is 0 while reset_n=0. In-flight reads are discarded and never reported.
- Arbitration (cycle t):
  - Search req starting at index rr_ptr, ascending, wrapping modulo NUM_REQ.
  - The first set bit k gets gnt[k]=1; all other gnt bits are 0.
  - If req==0, gnt=0 and no pointer change.
- Pointer update: on a grant to k, rr_ptr <= (k+1) mod NUM_REQ at the end of t. With no grant, rr_ptr holds.
- Address capture: on a grant, rom_address <= req_addr[k] at the end of t. With no grant, rom_address holds its previous value; the ROM read is harmless and untagged.
- Tag pipeline: a shift register of depth 1+ROM_LAT carries {valid, id}. Stage 0 loads {grant_any, k} at the end of t.
- Response: rd_valid=1 and rd_id=k in cycle t+1+ROM_LAT. rd_data is rom_q, combinational pass-through, gated to 0 when rd_valid=0.
- Handshake:
  - A requester holds req and req_addr stable until it sees gnt.
  - It may deassert req, or present a new address, in the cycle after gnt.
  - Dropping req before gnt is legal: the request is withdrawn and no response is produced.
- Back-to-back: a single requester holding req continuously is granted every cycle only if no other req is pending. Otherwise grants alternate per round-robin order.
- Fairness: worst-case wait from req assertion to gnt is NUM_REQ-1 cycles.
- Simultaneous events: a grant and its response are never in the same cycle. Up to 1+ROM_LAT reads are in flight, and responses return in grant order.
- X safety: req_addr of non-granted requesters is never sampled.

Optional Feature:
- Macro: SPRITE_ROM_ARB_STATS_EN
- With the macro defined:
  - Extra output port contention_cnt, 16 bits.
  - It counts cycles in which two or more req bits are set, saturating at 16'hFFFF.
  - Extra input stats_clr, 1 bit: synchronous clear, which has priority over increment.
  - contention_cnt resets to 0 on reset_n=0.
- Without the macro: neither port exists and no counter logic is generated. Core behaviour is identical.

Test Plan:
- Reset/idle: hold reset_n=0 5 cycles, then req=0 for 10 cycles -> gnt=0, rd_valid=0, rom_address=0 throughout.
- Single read (ROM_LAT=1): req=4'b0100, addr2=10'h155 at cycle 0 -> gnt=4'b0100 in cycle 0, rom_address=10'h155 in cycle 1, rd_valid=1 with rd_id=2 and rd_data=rom_q in cycle 2.
- Round-robin: req=4'b1111 held 8 cycles from rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3. Responses arrive with rd_id 0,1,2,3,0,1,2,3, each 2 cycles after its grant.
- Skip/wrap: rr_ptr=3, req=4'b0011 -> gnt=4'b0001, then 4'b0010, then 4'b0001.
- Reset mid-operation: after 2 grants with both reads in flight, pulse reset_n low asynchronously mid-cycle -> rd_valid drops immediately, no stale responses after release, and the next grant goes to index 0 first.
- Stats (macro on): req=4'b0011 for 5 cycles, then 4'b0001 for 3 cycles -> contention_cnt=5. Then stats_clr=1 for 1 cycle -> contention_cnt=0.
